// File: rtl/mux_arbiter8.sv
// Round-robin arbiter owning the select of a shared 8:1 32-bit mux.
// One requester holds the grant for at most MAX_BURST accepted beats, then one idle cycle.
module mux_arbiter8 #(
  parameter int MAX_BURST = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] req,
  input  logic       out_ready,
  output logic [2:0] sel,
  output logic [7:0] gnt,
  output logic       out_valid,
  output logic       busy
);

  typedef enum logic {IDLE, GRANT} state_t;

  localparam logic [7:0] LAST = 8'(MAX_BURST - 1);

  state_t     state_q, state_d;
  logic [2:0] ptr_q, ptr_d;
  logic [2:0] sel_q, sel_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] gnt_q, gnt_d;

  logic       found;
  logic [2:0] pick;
  logic [2:0] idx;
  logic       accept;
  logic       rel;

  assign busy      = (state_q == GRANT);
  assign out_valid = busy && req[sel_q];
  assign sel       = sel_q;
  assign gnt       = gnt_q;
  assign accept    = out_valid && out_ready;
  // A dropped request releases immediately; otherwise release on the last beat of the tenure.
  assign rel       = busy && (!req[sel_q] || (accept && (cnt_q == LAST)));

  // First requester at or after ptr, wrapping mod 8.
  always_comb begin
    found = 1'b0;
    pick  = ptr_q;
    idx   = '0;
    for (int k = 0; k < 8; k++) begin
      idx = ptr_q + 3'(k);
      if (!found && req[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    sel_d   = sel_q;
    cnt_d   = cnt_q;
    gnt_d   = gnt_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          state_d = GRANT;
          sel_d   = pick;
          gnt_d   = 8'b1 << pick;
          cnt_d   = '0;
        end
      end
      GRANT: begin
        if (rel) begin
          state_d = IDLE;
          gnt_d   = '0;
          ptr_d   = sel_q + 3'd1;
          cnt_d   = '0;
        end else if (accept) begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      sel_q   <= '0;
      cnt_q   <= '0;
      gnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
    end
  end

endmodule

// File: tb/tb_mux_arbiter8.sv
// Self-checking bench for mux_arbiter8: directed scenarios plus randomized traffic
// compared against a tenure-level reference model.
module tb_mux_arbiter8;
  localparam int MB = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] req;
  logic       out_ready;
  logic [2:0] sel;
  logic [7:0] gnt;
  logic       out_valid;
  logic       busy;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: who owns the mux (-1 = nobody), where the next search starts,
  // last select, and beats delivered in the current tenure.
  int m_owner = -1;
  int m_ptr   = 0;
  int m_sel   = 0;
  int m_beats = 0;

  mux_arbiter8 #(.MAX_BURST(MB)) dut (
    .clk(clk), .rst(rst), .req(req), .out_ready(out_ready),
    .sel(sel), .gnt(gnt), .out_valid(out_valid), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [12:0] obs();
    return {gnt, sel, out_valid, busy};
  endfunction

  function automatic logic [12:0] m_exp();
    logic [7:0] g;
    logic       v, b;
    g = '0; v = 1'b0; b = 1'b0;
    if (m_owner >= 0) begin
      g[m_owner] = 1'b1;
      v = req[m_owner];
      b = 1'b1;
    end
    return {g, m_sel[2:0], v, b};
  endfunction

  task automatic drive(input logic [7:0] r, input logic rd, input logic rs);
    req = r; out_ready = rd; rst = rs;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst) begin
      m_owner = -1; m_ptr = 0; m_sel = 0; m_beats = 0;
    end else if (m_owner < 0) begin
      for (int j = 0; j < 8; j++) begin
        if (m_owner < 0 && req[(m_ptr + j) % 8]) begin
          m_owner = (m_ptr + j) % 8;
          m_sel   = m_owner;
          m_beats = 0;
        end
      end
    end else if (!req[m_owner]) begin
      m_ptr = (m_owner + 1) % 8; m_owner = -1; m_beats = 0;
    end else if (out_ready) begin
      m_beats++;
      if (m_beats == MB) begin
        m_ptr = (m_owner + 1) % 8; m_owner = -1; m_beats = 0;
      end
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    drive(8'h00, 1'b0, 1'b1);
    tick();
    drive(8'h00, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    drive(8'hFF, 1'b1, 1'b1);
    tick();
    for (int c = 0; c < 2; c++) begin
      drive(8'hFF, 1'b1, 1'b1);
      n_checks++;
      if (obs() !== 13'h0) $display("FAIL reset_hold cyc%0d got %h exp %h", c, obs(), 13'h0);
      else n_pass++;
      tick();
    end
    drive(8'hFF, 1'b1, 1'b0);
    n_checks++;
    if (obs() !== 13'h0) $display("FAIL reset_release got %h exp %h", obs(), 13'h0);
    else n_pass++;
    tick();
    n_checks++;
    if (gnt !== 8'h01 || sel !== 3'd0 || busy !== 1'b1)
      $display("FAIL reset_first_grant got gnt=%h sel=%0d exp gnt=01 sel=0", gnt, sel);
    else n_pass++;
  endtask

  task automatic test_single();
    int beats, cyc;
    do_reset();
    drive(8'h08, 1'b1, 1'b0);
    tick();
    n_checks++;
    if (gnt !== 8'h08 || sel !== 3'd3) $display("FAIL single_grant got gnt=%h sel=%0d exp gnt=08 sel=3", gnt, sel);
    else n_pass++;
    beats = 0; cyc = 0;
    while (busy === 1'b1 && cyc < 20) begin
      drive(8'h08, 1'b1, 1'b0);
      if (out_valid && out_ready) beats++;
      tick();
      cyc++;
    end
    n_checks++;
    if (beats != MB || cyc >= 20) $display("FAIL single_beats got %0d exp %0d", beats, MB);
    else n_pass++;
    drive(8'h08, 1'b1, 1'b0);
    n_checks++;
    if (gnt !== 8'h00 || busy !== 1'b0) $display("FAIL single_bubble got gnt=%h exp 00", gnt);
    else n_pass++;
    tick();
    n_checks++;
    if (gnt !== 8'h08 || sel !== 3'd3) $display("FAIL single_regrant got gnt=%h sel=%0d exp gnt=08 sel=3", gnt, sel);
    else n_pass++;
  endtask

  task automatic test_round_robin();
    logic [12:0] e;
    int k, ph;
    do_reset();
    for (int c = 0; c < 42; c++) begin
      drive(8'hFF, 1'b1, 1'b0);
      // Each tenure is MB beats plus one idle cycle; grants rotate 0..7.
      if (c == 0) e = 13'h0;
      else begin
        k  = (c - 1) / (MB + 1);
        ph = (c - 1) % (MB + 1);
        if (ph < MB) e = {8'(1 << (k % 8)), 3'(k % 8), 1'b1, 1'b1};
        else         e = {8'h00, 3'(k % 8), 1'b0, 1'b0};
      end
      n_checks++;
      if (obs() !== e) $display("FAIL round_robin cyc%0d got %h exp %h", c, obs(), e);
      else n_pass++;
      tick();
    end
  endtask

  task automatic test_back_pressure();
    do_reset();
    drive(8'h04, 1'b1, 1'b0);
    tick();
    drive(8'h04, 1'b1, 1'b0);
    tick();
    for (int c = 0; c < 3; c++) begin
      drive(8'h04, 1'b0, 1'b0);
      n_checks++;
      if (out_valid !== 1'b1 || gnt !== 8'h04 || sel !== 3'd2)
        $display("FAIL bp_hold cyc%0d got ov=%b gnt=%h sel=%0d exp ov=1 gnt=04 sel=2", c, out_valid, gnt, sel);
      else n_pass++;
      tick();
    end
    for (int c = 0; c < 3; c++) begin
      drive(8'h04, 1'b1, 1'b0);
      n_checks++;
      if (out_valid !== 1'b1 || gnt !== 8'h04)
        $display("FAIL bp_resume beat%0d got ov=%b gnt=%h exp ov=1 gnt=04", c, out_valid, gnt);
      else n_pass++;
      tick();
    end
    drive(8'h04, 1'b1, 1'b0);
    n_checks++;
    if (gnt !== 8'h00 || busy !== 1'b0) $display("FAIL bp_release got gnt=%h exp 00", gnt);
    else n_pass++;
    tick();
  endtask

  task automatic test_early_release();
    do_reset();
    drive(8'h24, 1'b1, 1'b0);
    tick();
    for (int c = 0; c < 2; c++) begin
      drive(8'h24, 1'b1, 1'b0);
      tick();
    end
    drive(8'h20, 1'b1, 1'b0);
    n_checks++;
    if (out_valid !== 1'b0 || gnt !== 8'h04) $display("FAIL early_drop got ov=%b gnt=%h exp ov=0 gnt=04", out_valid, gnt);
    else n_pass++;
    tick();
    drive(8'h20, 1'b1, 1'b0);
    n_checks++;
    if (gnt !== 8'h00) $display("FAIL early_bubble got gnt=%h exp 00", gnt);
    else n_pass++;
    tick();
    n_checks++;
    if (gnt !== 8'h20 || sel !== 3'd5) $display("FAIL early_next got gnt=%h sel=%0d exp gnt=20 sel=5", gnt, sel);
    else n_pass++;
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    drive(8'h40, 1'b1, 1'b0);
    tick();
    drive(8'h40, 1'b1, 1'b0);
    tick();
    drive(8'h40, 1'b1, 1'b1);
    tick();
    drive(8'h41, 1'b1, 1'b0);
    n_checks++;
    if (obs() !== 13'h0) $display("FAIL midrst_outputs got %h exp %h", obs(), 13'h0);
    else n_pass++;
    tick();
    n_checks++;
    if (gnt !== 8'h01 || sel !== 3'd0) $display("FAIL midrst_regrant got gnt=%h sel=%0d exp gnt=01 sel=0", gnt, sel);
    else n_pass++;
  endtask

  task automatic test_random();
    logic [7:0] r;
    logic       rd, rs;
    int         errs;
    errs = 0;
    r = 8'($urandom);
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(3) == 0) r = 8'($urandom);
      if ($urandom_range(5) == 0) r[$urandom_range(7)] = 1'b0;
      rd = ($urandom_range(3) != 0);
      rs = ($urandom_range(150) == 0);
      drive(r, rd, rs);
      n_checks++;
      if (obs() !== m_exp()) begin
        if (errs < 10) $display("FAIL random cyc%0d req=%h got %h exp %h", c, r, obs(), m_exp());
        errs++;
      end else n_pass++;
      tick();
    end
  endtask

  initial begin
    req = '0; out_ready = 1'b0; rst = 1'b1;
    test_reset();
    test_single();
    test_round_robin();
    test_back_pressure();
    test_early_release();
    test_reset_mid_burst();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
